// File: rtl/error_countdown_timer.sv
// Error latch and user re-entry countdown feeding the display controller.
// Holds the active error code and shows the remaining seconds as two BCD digits.
// Emits a single-cycle timeout_pulse when the count expires.
module error_countdown_timer #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned DEFAULT_SECS = 10,
    parameter int unsigned MIN_SECS     = 5,
    parameter int unsigned MAX_SECS     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       err_valid,
    input  logic [3:0] err_in,
    input  logic       retry_pulse,
    input  logic       cfg_we,
    input  logic [4:0] cfg_secs,
    output logic       cfg_ack,
    output logic       cfg_nack,
    output logic [3:0] error_code,
    output logic [3:0] countdown_tens,
    output logic [3:0] countdown_ones,
    output logic       timeout_pulse,
    output logic       busy
);

    localparam int unsigned SW = 5;
    localparam int unsigned DW = 4;
    // At least one bit so CLK_HZ = 1 still elaborates.
    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_HZ - 1);
    localparam logic [SW-1:0] CFG_MIN = SW'(MIN_SECS);
    localparam logic [SW-1:0] CFG_MAX = SW'(MAX_SECS);
    localparam logic [SW-1:0] CFG_RST = SW'(DEFAULT_SECS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        EXPIRE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [PW-1:0]   prescaler, prescaler_nx;
    logic [SW-1:0]   cfg_reg, cfg_reg_nx;
    logic [DW-1:0]   code_nx, tens_nx, ones_nx;
    logic [DW-1:0]   cfg_tens, cfg_ones;
    logic            timeout_nx, busy_nx, ack_nx, nack_nx;
    logic            cfg_ok, arm_req, tick;

    // Reload digits for the configured length; cfg_reg never exceeds 31.
    assign cfg_tens = DW'(cfg_reg / SW'(10));
    assign cfg_ones = DW'(cfg_reg % SW'(10));
    assign cfg_ok   = (cfg_secs >= CFG_MIN) && (cfg_secs <= CFG_MAX);
    assign arm_req  = err_valid && (err_in != '0);
    assign tick     = (prescaler == PS_LAST);

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            prescaler      <= '0;
            cfg_reg        <= CFG_RST;
            error_code     <= '0;
            countdown_tens <= '0;
            countdown_ones <= '0;
            timeout_pulse  <= 1'b0;
            busy           <= 1'b0;
            cfg_ack        <= 1'b0;
            cfg_nack       <= 1'b0;
        end else begin
            state          <= state_nx;
            prescaler      <= prescaler_nx;
            cfg_reg        <= cfg_reg_nx;
            error_code     <= code_nx;
            countdown_tens <= tens_nx;
            countdown_ones <= ones_nx;
            timeout_pulse  <= timeout_nx;
            busy           <= busy_nx;
            cfg_ack        <= ack_nx;
            cfg_nack       <= nack_nx;
        end
    end

    // Next-state, countdown and config-write logic.
    always_comb begin
        state_nx     = state;
        prescaler_nx = prescaler;
        code_nx      = error_code;
        tens_nx      = countdown_tens;
        ones_nx      = countdown_ones;
        timeout_nx   = 1'b0;
        cfg_reg_nx   = cfg_reg;
        ack_nx       = 1'b0;
        nack_nx      = 1'b0;

        // Config writes are taken in any state and only affect later arms.
        if (cfg_we) begin
            if (cfg_ok) begin
                cfg_reg_nx = cfg_secs;
                ack_nx     = 1'b1;
            end else begin
                nack_nx    = 1'b1;
            end
        end

        unique case (state)
            IDLE: begin
                code_nx      = '0;
                tens_nx      = '0;
                ones_nx      = '0;
                prescaler_nx = '0;
                if (arm_req) begin
                    state_nx = COUNT;
                    code_nx  = err_in;
                    tens_nx  = cfg_tens;
                    ones_nx  = cfg_ones;
                end
            end
            COUNT: begin
                if (retry_pulse) begin
                    state_nx     = IDLE;
                    code_nx      = '0;
                    tens_nx      = '0;
                    ones_nx      = '0;
                    prescaler_nx = '0;
                end else if (arm_req) begin
                    code_nx      = err_in;
                    tens_nx      = cfg_tens;
                    ones_nx      = cfg_ones;
                    prescaler_nx = '0;
                end else if (tick) begin
                    prescaler_nx = '0;
                    if ((countdown_tens == '0) && (countdown_ones <= DW'(1))) begin
                        ones_nx    = '0;
                        state_nx   = EXPIRE;
                        timeout_nx = 1'b1;
                    end else if (countdown_ones == '0) begin
                        ones_nx = DW'(9);
                        tens_nx = countdown_tens - DW'(1);
                    end else begin
                        ones_nx = countdown_ones - DW'(1);
                    end
                end else begin
                    prescaler_nx = prescaler + PW'(1);
                end
            end
            EXPIRE: begin
                state_nx     = IDLE;
                code_nx      = '0;
                tens_nx      = '0;
                ones_nx      = '0;
                prescaler_nx = '0;
            end
            default: begin
                state_nx     = IDLE;
                code_nx      = '0;
                tens_nx      = '0;
                ones_nx      = '0;
                prescaler_nx = '0;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: tb/tb_error_countdown_timer.sv
// Scoreboard bench for error_countdown_timer with a seconds-level reference model.
module tb_error_countdown_timer;

    localparam int unsigned HZ = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       err_valid, retry_pulse, cfg_we;
    logic [3:0] err_in;
    logic [4:0] cfg_secs;
    logic       cfg_ack, cfg_nack, timeout_pulse, busy;
    logic [3:0] error_code, countdown_tens, countdown_ones;

    int n_cmp = 0;
    int n_bad = 0;
    int n_timeout = 0;

    // Expected output bundle: {busy, timeout, ack, nack, code, tens, ones}
    logic [15:0] exp_q[$];

    // Reference model state (whole seconds rather than BCD digits)
    int m_state;   // 0 idle, 1 counting, 2 expired
    int m_code, m_rem, m_cnt, m_cfg;
    bit m_tp, m_ack, m_nack;

    error_countdown_timer #(
        .CLK_HZ(HZ), .DEFAULT_SECS(10), .MIN_SECS(5), .MAX_SECS(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .err_valid(err_valid), .err_in(err_in),
        .retry_pulse(retry_pulse),
        .cfg_we(cfg_we), .cfg_secs(cfg_secs),
        .cfg_ack(cfg_ack), .cfg_nack(cfg_nack),
        .error_code(error_code),
        .countdown_tens(countdown_tens), .countdown_ones(countdown_ones),
        .timeout_pulse(timeout_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] observed();
        return {busy, timeout_pulse, cfg_ack, cfg_nack,
                error_code, countdown_tens, countdown_ones};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_code = 0; m_rem = 0; m_cnt = 0; m_cfg = 10;
        m_tp = 0; m_ack = 0; m_nack = 0;
    endtask

    // Advance the model by one clock edge with the given inputs.
    task automatic model_step(input bit ev, input int ei, input bit rt,
                              input bit we, input int cs);
        int old_cfg;
        old_cfg = m_cfg;
        m_ack = we && cs >= 5 && cs <= 15;
        m_nack = we && !(cs >= 5 && cs <= 15);
        if (m_ack) m_cfg = cs;
        m_tp = 0;
        case (m_state)
            0: if (ev && ei != 0) begin
                m_state = 1; m_code = ei; m_rem = old_cfg; m_cnt = 0;
            end
            1: if (rt) begin
                m_state = 0; m_code = 0; m_rem = 0;
            end else if (ev && ei != 0) begin
                m_code = ei; m_rem = old_cfg; m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == HZ) begin
                    m_cnt = 0;
                    m_rem--;
                    if (m_rem == 0) begin
                        m_state = 2; m_tp = 1;
                    end
                end
            end
            default: begin
                m_state = 0; m_code = 0; m_rem = 0;
            end
        endcase
    endtask

    function automatic logic [15:0] model_out();
        return {1'(m_state != 0), 1'(m_tp), 1'(m_ack), 1'(m_nack),
                4'(m_code), 4'(m_rem / 10), 4'(m_rem % 10)};
    endfunction

    // One cycle: drive at negedge, push expectation, compare after the edge.
    task automatic step(input bit ev, input int ei, input bit rt,
                        input bit we, input int cs, input string tag);
        logic [15:0] e;
        err_valid = ev; err_in = 4'(ei); retry_pulse = rt;
        cfg_we = we; cfg_secs = 5'(cs);
        model_step(ev, ei, rt, we, cs);
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, 32'(observed()), 32'(e));
        if (timeout_pulse) n_timeout++;
        @(negedge clk);
        err_valid = 0; retry_pulse = 0; cfg_we = 0;
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        rst_n = 0;
        err_valid = 0; err_in = 0; retry_pulse = 0; cfg_we = 0; cfg_secs = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", 32'(observed()), 32'h0);
        @(negedge clk);
        rst_n = 1;

        // Default 10 s countdown to expiry
        n_timeout = 0;
        step(1, 3, 0, 0, 0, "arm_default");
        check("arm_digits", 32'({error_code, countdown_tens, countdown_ones, busy}), 32'({4'd3, 4'd1, 4'd0, 1'b1}));
        idle(10 * HZ + 3, "run_default");
        check("timeout_count_default", 32'(n_timeout), 32'd1);

        // Accept 15, cross the 10 -> 09 boundary, abort
        step(0, 0, 0, 1, 15, "cfg_15");
        step(1, 1, 0, 0, 0, "arm_15");
        check("arm_15_digits", 32'({countdown_tens, countdown_ones}), 32'h15);
        idle(6 * HZ + 2, "cross_boundary");
        check("boundary_digits", 32'({countdown_tens, countdown_ones}), 32'h09);
        step(0, 0, 1, 0, 0, "retry_15");

        // Out-of-range writes rejected, previous value kept
        step(0, 0, 0, 1, 4, "cfg_4_nack");
        step(0, 0, 0, 1, 16, "cfg_16_nack");
        step(1, 6, 0, 0, 0, "arm_after_nack");
        check("nack_keeps_15", 32'({countdown_tens, countdown_ones}), 32'h15);
        // Write during count must not disturb the running value
        step(0, 0, 0, 1, 7, "cfg_7_in_count");
        idle(15 * HZ + 2, "run_15");
        step(1, 4, 0, 0, 0, "arm_7");
        check("arm_7_digits", 32'({countdown_tens, countdown_ones}), 32'h07);

        // Retry after 23 cycles: no timeout
        step(0, 0, 1, 0, 0, "retry_7");
        n_timeout = 0;
        step(1, 2, 0, 0, 0, "arm_err2");
        idle(23, "wait_23");
        step(0, 0, 1, 0, 0, "retry_23");
        idle(10 * HZ, "after_retry");
        check("no_timeout_after_retry", 32'(n_timeout), 32'd0);

        // Re-arm on the tick cycle, then retry + err together
        step(1, 2, 0, 0, 0, "arm_tick_test");
        idle(HZ - 1, "to_tick");
        step(1, 5, 0, 0, 0, "rearm_on_tick");
        check("rearm_digits", 32'({error_code, countdown_tens, countdown_ones}), 32'h507);
        idle(HZ + 3, "after_rearm");
        step(1, 9, 1, 0, 0, "retry_wins");
        check("retry_wins_idle", 32'({busy, error_code}), 32'h0);
        step(1, 0, 0, 0, 0, "zero_err_ignored");

        // Async reset mid-count at 07 (cfg 15: 8 ticks)
        step(0, 0, 0, 1, 15, "cfg_15_again");
        step(1, 8, 0, 0, 0, "arm_rst_test");
        idle(8 * HZ + 4, "to_07");
        check("at_07", 32'({countdown_tens, countdown_ones}), 32'h07);
        #2 rst_n = 0;
        #1 check("async_reset", 32'(observed()), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step(1, 1, 0, 0, 0, "arm_after_reset");
        check("default_after_reset", 32'({countdown_tens, countdown_ones}), 32'h10);
        idle(3, "tail");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop if the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
